// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern scheduler.
// Holds the FSM state encoding, the pattern mode codes and the pattern
// that each mode starts from when a configuration is loaded.
package led_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_BLINK  = 2'b00;
   localparam logic [1:0] MODE_SHIFT  = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_COUNT  = 2'b11;

   localparam logic [3:0] INIT_BLINK  = 4'b1111;
   localparam logic [3:0] INIT_SHIFT  = 4'b0001;
   localparam logic [3:0] INIT_BOUNCE = 4'b0001;
   localparam logic [3:0] INIT_COUNT  = 4'b0000;

   // Starting LED value for a freshly loaded pattern.
   function automatic logic [3:0] init_pattern(input logic [1:0] mode);
      logic [3:0] pat;
      case (mode)
         MODE_BLINK:  pat = INIT_BLINK;
         MODE_SHIFT:  pat = INIT_SHIFT;
         MODE_BOUNCE: pat = INIT_BOUNCE;
         default:     pat = INIT_COUNT;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler.
// Ports:
//   Clk50M - system clock
//   Rst    - synchronous active-high reset
//   en     - count enable
//   clr    - synchronous clear, wins over en
//   tick   - one-cycle pulse while the counter sits at TICK_DIV-1
module tick_prescaler #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic Clk50M,
   input  logic Rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk50M) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_scheduler.sv
// Four-LED pattern scheduler.
// Runs one of four patterns (BLINK, SHIFT, BOUNCE, COUNT), advancing one
// step every period_eff prescaler ticks. A configuration is taken over a
// valid/ready handshake; stop blanks the LEDs and returns to idle.
// Ports:
//   Clk50M, Rst          - clock and synchronous active-high reset
//   cfg_valid/cfg_ready  - configuration handshake
//   cfg_mode, cfg_period - pattern select and ticks per step (0 acts as 1)
//   stop                 - halt request, blanks the LEDs
//   busy                 - a pattern is loaded or running
//   step_pulse           - high in the cycle led shows a new step value
//   led                  - LED drive, 1 = on
module led_pattern_scheduler
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV = 25_000_000,
   parameter int NUM_LED  = 4          // only 4 is supported
) (
   input  logic               Clk50M,
   input  logic               Rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [1:0]         cfg_mode,
   input  logic [3:0]         cfg_period,
   input  logic               stop,
   output logic               busy,
   output logic               step_pulse,
   output logic [NUM_LED-1:0] led
);

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [3:0]         period_q, period_d;
   logic [3:0]         step_cnt_q, step_cnt_d;
   logic [NUM_LED-1:0] led_q, led_d;
   logic               dir_up_q, dir_up_d;
   logic               busy_q, busy_d;
   logic               pulse_q, pulse_d;

   logic               accept;
   logic               tick;
   logic               presc_clr;
   logic [NUM_LED-1:0] led_step;

   assign cfg_ready = (state_q != ST_LOAD) && !stop;
   assign accept    = cfg_valid && cfg_ready;

   // Prescaler only runs in RUN; any restart or stop zeroes it so the first
   // step of a new pattern lands a full period after the load.
   assign presc_clr = stop || accept || (state_q != ST_RUN);

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_presc (
      .Clk50M(Clk50M),
      .Rst   (Rst),
      .en    (state_q == ST_RUN),
      .clr   (presc_clr),
      .tick  (tick)
   );

   // Next LED value for the current mode.
   always_comb begin
      case (mode_q)
         MODE_BLINK:  led_step = ~led_q;
         MODE_SHIFT:  led_step = {led_q[2:0], led_q[3]};
         MODE_BOUNCE: led_step = dir_up_q ? (led_q << 1) : (led_q >> 1);
         default:     led_step = led_q + 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      period_d   = period_q;
      step_cnt_d = step_cnt_q;
      led_d      = led_q;
      dir_up_d   = dir_up_q;
      busy_d     = busy_q;
      pulse_d    = 1'b0;

      if (stop) begin
         state_d    = ST_IDLE;
         led_d      = '0;
         busy_d     = 1'b0;
         step_cnt_d = '0;
         dir_up_d   = 1'b1;
      end else if (accept) begin
         // Restart: the old pattern takes no further step.
         state_d    = ST_LOAD;
         mode_d     = cfg_mode;
         period_d   = (cfg_period == 4'd0) ? 4'd1 : cfg_period;
         step_cnt_d = '0;
         busy_d     = 1'b1;
      end else begin
         case (state_q)
            ST_LOAD: begin
               state_d    = ST_RUN;
               busy_d     = 1'b1;
               step_cnt_d = '0;
               led_d      = init_pattern(mode_q);
               dir_up_d   = 1'b1;
            end
            ST_RUN: begin
               if (tick) begin
                  if (step_cnt_q == period_q - 4'd1) begin
                     step_cnt_d = '0;
                     led_d      = led_step;
                     pulse_d    = 1'b1;
                     // Bounce turns around on the end LEDs without repeating them.
                     if (led_step == 4'b1000) dir_up_d = 1'b0;
                     if (led_step == 4'b0001) dir_up_d = 1'b1;
                  end else begin
                     step_cnt_d = step_cnt_q + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk50M) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         period_q   <= '0;
         step_cnt_q <= '0;
         led_q      <= '0;
         dir_up_q   <= 1'b1;
         busy_q     <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         period_q   <= period_d;
         step_cnt_q <= step_cnt_d;
         led_q      <= led_d;
         dir_up_q   <= dir_up_d;
         busy_q     <= busy_d;
         pulse_q    <= pulse_d;
      end
   end

   assign led        = led_q;
   assign busy       = busy_q;
   assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Bench for led_pattern_scheduler with TICK_DIV=4.
module tb_led_pattern_scheduler;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] period = 4'd0;
   logic       ready;
   logic       busy;
   logic       pulse;
   logic [3:0] led;

   always #5 clk = ~clk;

   led_pattern_scheduler #(.TICK_DIV(TD), .NUM_LED(4)) dut (
      .Clk50M    (clk),
      .Rst       (rst),
      .cfg_valid (valid),
      .cfg_ready (ready),
      .cfg_mode  (mode),
      .cfg_period(period),
      .stop      (stop),
      .busy      (busy),
      .step_pulse(pulse),
      .led       (led)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: elapsed edges since the load, pattern by step index.
   int         m_state = 0;   // 0 idle, 1 load, 2 run
   int         m_mode = 0;
   int         m_p = 1;
   int         m_el = 0;
   logic [3:0] m_led = 4'd0;
   bit         m_busy = 1'b0;
   bit         m_pulse = 1'b0;
   bit         m_known = 1'b0;

   int         npulse;
   logic [3:0] seen[$];

   typedef struct {
      bit         r;
      bit         v;
      logic [1:0] md;
      logic [3:0] pr;
      bit         s;
      logic [3:0] e_led;
      bit         e_busy;
      bit         e_pulse;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [3:0] pat(int md, int k);
      int b[6] = '{1, 2, 4, 8, 4, 2};
      case (md)
         0:       return (k % 2 == 0) ? 4'hF : 4'h0;
         1:       return 4'(1 << (k % 4));
         2:       return 4'(b[k % 6]);
         default: return 4'(k % 16);
      endcase
   endfunction

   function automatic vec_t mk(bit r, bit v, logic [1:0] md, logic [3:0] pr, bit s,
                               logic [3:0] el, bit eb, bit ep);
      vec_t t;
      t.r = r; t.v = v; t.md = md; t.pr = pr; t.s = s;
      t.e_led = el; t.e_busy = eb; t.e_pulse = ep;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check cfg_ready, model the edge, check outputs.
   task automatic cyc(input bit r, input bit v, input logic [1:0] md,
                      input logic [3:0] pr, input bit s);
      @(negedge clk);
      rst = r; valid = v; mode = md; period = pr; stop = s;
      #1;
      if (m_known && !r) chk("cfg_ready", int'(ready), int'(m_state != 1 && !s));
      @(posedge clk);
      if (r) begin
         m_state = 0; m_led = 4'd0; m_busy = 0; m_pulse = 0; m_known = 1;
      end else if (s) begin
         m_state = 0; m_led = 4'd0; m_busy = 0; m_pulse = 0;
      end else if (v && m_state != 1) begin
         m_state = 1; m_mode = int'(md); m_p = (pr == 0) ? 1 : int'(pr);
         m_busy = 1; m_pulse = 0;
      end else if (m_state == 1) begin
         m_state = 2; m_el = 0; m_led = pat(m_mode, 0); m_pulse = 0;
      end else if (m_state == 2) begin
         m_el++;
         if (m_el % (TD * m_p) == 0) begin
            m_pulse = 1;
            m_led = pat(m_mode, m_el / (TD * m_p));
         end else begin
            m_pulse = 0;
         end
      end else begin
         m_pulse = 0;
      end
      #1;
      chk("led", int'(led), int'(m_led));
      chk("busy", int'(busy), int'(m_busy));
      chk("step_pulse", int'(pulse), int'(m_pulse));
      if (pulse) begin
         npulse++;
         seen.push_back(led);
      end
   endtask

   task automatic idle_run(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 4'd0, 0);
   endtask

   initial begin
      int        k;
      logic [3:0] exp_b[8];

      // Table: reset, idle, SHIFT period 2 through a full rotation.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 2'd0, 4'd0, 0, 4'd0, 0, 0));
      tbl.push_back(mk(0, 0, 2'd0, 4'd0, 0, 4'd0, 0, 0));
      tbl.push_back(mk(0, 1, 2'd1, 4'd2, 0, 4'd0, 1, 0));
      tbl.push_back(mk(0, 0, 2'd0, 4'd0, 0, 4'b0001, 1, 0));
      for (int j = 1; j <= 32; j++)
         tbl.push_back(mk(0, 0, 2'd0, 4'd0, 0, 4'(1 << ((j / 8) % 4)), 1, (j % 8) == 0));

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].v, tbl[i].md, tbl[i].pr, tbl[i].s);
         chk("tbl_led", int'(led), int'(tbl[i].e_led));
         chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
         chk("tbl_pulse", int'(pulse), int'(tbl[i].e_pulse));
      end
      $display("table vectors applied: %0d", tbl.size());

      // Reset then 40 idle cycles: nothing moves.
      for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, 4'd0, 0);
      npulse = 0;
      idle_run(40);
      chk("idle_pulses", npulse, 0);
      chk("idle_led", int'(led), 0);
      $display("reset+idle sequence done");

      // BOUNCE with period 0 (acts as 1).
      cyc(0, 1, 2'd2, 4'd0, 0);
      cyc(0, 0, 2'd0, 4'd0, 0);
      chk("bounce_init", int'(led), 1);
      npulse = 0; seen.delete();
      idle_run(32);
      exp_b = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2, 4'd4};
      chk("bounce_steps", npulse, 8);
      for (int i = 0; i < 8; i++)
         chk("bounce_seq", (i < seen.size()) ? int'(seen[i]) : -1, int'(exp_b[i]));
      $display("bounce sequence done");

      // COUNT period 1: 16 steps wrap back to 0000.
      cyc(0, 1, 2'd3, 4'd1, 0);
      cyc(0, 0, 2'd0, 4'd0, 0);
      npulse = 0;
      idle_run(64);
      chk("count_steps", npulse, 16);
      chk("count_wrap", int'(led), 0);
      $display("count sequence done");

      // BLINK period 1.
      cyc(0, 1, 2'd0, 4'd1, 0);
      cyc(0, 0, 2'd0, 4'd0, 0);
      chk("blink_init", int'(led), 15);
      idle_run(8);
      $display("blink sequence done");

      // Reconfigure one cycle before a SHIFT step is due.
      cyc(0, 1, 2'd1, 4'd1, 0);
      cyc(0, 0, 2'd0, 4'd0, 0);
      idle_run(3);
      cyc(0, 1, 2'd3, 4'd3, 0);
      chk("reconf_no_step", int'(pulse), 0);
      chk("reconf_led_held", int'(led), 1);
      cyc(0, 0, 2'd0, 4'd0, 0);
      chk("reconf_load_led", int'(led), 0);
      k = 0;
      npulse = 0;
      while (npulse == 0 && k < 40) begin
         cyc(0, 0, 2'd0, 4'd0, 0);
         k++;
      end
      chk("reconf_first_step_cycles", k, 12);
      $display("reconfigure sequence done");

      // stop together with cfg_valid during RUN.
      idle_run(5);
      cyc(0, 1, 2'd2, 4'd2, 1);
      chk("stop_led", int'(led), 0);
      chk("stop_busy", int'(busy), 0);
      idle_run(3);
      chk("stop_stays_idle", int'(busy), 0);
      $display("stop sequence done");

      // Rst mid-RUN.
      cyc(0, 1, 2'd3, 4'd1, 0);
      cyc(0, 0, 2'd0, 4'd0, 0);
      idle_run(9);
      cyc(1, 1, 2'd1, 4'd1, 0);
      chk("rst_led", int'(led), 0);
      chk("rst_busy", int'(busy), 0);
      idle_run(6);
      $display("reset-in-run sequence done");

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) == 0),
             2'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)),
             ($urandom_range(0, 39) == 0));
      end
      $display("random traffic done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
